// File: rtl/desc_mem_arbiter.sv
// desc_mem_arbiter: round-robin TX/RX master arbiter for the descriptor RAM.
// Define DESC_MEM_ARB_LOCK_EN to add per-master lock for atomic RMW.
module desc_mem_arbiter #(
    parameter int ADDR_W       = 11,
    parameter int DATA_W       = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [ADDR_W-1:0]   m0_address,
    input  logic [DATA_W/8-1:0] m0_byteenable,
    input  logic                m0_read,
    input  logic                m0_write,
    input  logic [DATA_W-1:0]   m0_writedata,
    output logic                m0_waitrequest,
    output logic [DATA_W-1:0]   m0_readdata,
    output logic                m0_readdatavalid,
    input  logic [ADDR_W-1:0]   m1_address,
    input  logic [DATA_W/8-1:0] m1_byteenable,
    input  logic                m1_read,
    input  logic                m1_write,
    input  logic [DATA_W-1:0]   m1_writedata,
    output logic                m1_waitrequest,
    output logic [DATA_W-1:0]   m1_readdata,
    output logic                m1_readdatavalid,
`ifdef DESC_MEM_ARB_LOCK_EN
    input  logic                m0_lock,
    input  logic                m1_lock,
`endif
    output logic [ADDR_W-1:0]   mem_address,
    output logic [DATA_W/8-1:0] mem_byteenable,
    output logic                mem_chipselect,
    output logic                mem_write,
    output logic [DATA_W-1:0]   mem_writedata,
    output logic                mem_clken,
    input  logic [DATA_W-1:0]   mem_readdata
);

    logic                    r_last;
    logic [READ_LATENCY-1:0] r_tag_v;
    logic [READ_LATENCY-1:0] r_tag_id;

    logic w_req0;
    logic w_req1;
    logic w_can0;
    logic w_can1;
    logic w_gnt0;
    logic w_gnt1;
    logic w_any;
    logic w_push;
    logic w_block0;
    logic w_block1;

    assign w_req0 = m0_read | m0_write;
    assign w_req1 = m1_read | m1_write;

`ifdef DESC_MEM_ARB_LOCK_EN
    logic r_lock_v;
    logic r_lock_id;
    logic w_own_gnt;
    logic w_own_req;
    logic w_own_lock;

    assign w_block0   = r_lock_v & r_lock_id;
    assign w_block1   = r_lock_v & ~r_lock_id;
    assign w_own_gnt  = r_lock_id ? w_gnt1 : w_gnt0;
    assign w_own_req  = r_lock_id ? w_req1 : w_req0;
    assign w_own_lock = r_lock_id ? m1_lock : m0_lock;

    // Owner keeps the lock while it asserts lock; dropping it releases.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_lock_v  <= 1'b0;
            r_lock_id <= 1'b0;
        end else if (r_lock_v) begin
            if (w_own_gnt)
                r_lock_v <= w_own_lock;
            else if (!w_own_req && !w_own_lock)
                r_lock_v <= 1'b0;
        end else if (w_gnt0 && m0_lock) begin
            r_lock_v  <= 1'b1;
            r_lock_id <= 1'b0;
        end else if (w_gnt1 && m1_lock) begin
            r_lock_v  <= 1'b1;
            r_lock_id <= 1'b1;
        end
    end
`else
    assign w_block0 = 1'b0;
    assign w_block1 = 1'b0;
`endif

    always_comb begin
        w_can0 = reset_n & w_req0 & ~w_block0;
        w_can1 = reset_n & w_req1 & ~w_block1;
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (w_can0 && w_can1) begin
            w_gnt0 = r_last;
            w_gnt1 = ~r_last;
        end else begin
            w_gnt0 = w_can0;
            w_gnt1 = w_can1;
        end
    end

    assign w_any  = w_gnt0 | w_gnt1;
    assign w_push = (w_gnt0 & m0_read & ~m0_write)
                  | (w_gnt1 & m1_read & ~m1_write);

    assign mem_address    = w_gnt1 ? m1_address    : m0_address;
    assign mem_byteenable = w_gnt1 ? m1_byteenable : m0_byteenable;
    assign mem_writedata  = w_gnt1 ? m1_writedata  : m0_writedata;
    assign mem_chipselect = w_any;
    assign mem_write      = w_gnt1 ? m1_write : (w_gnt0 & m0_write);
    assign mem_clken      = reset_n;

    assign m0_waitrequest = ~reset_n | (w_req0 & ~w_gnt0);
    assign m1_waitrequest = ~reset_n | (w_req1 & ~w_gnt1);

    // Tag shift register depth equals RAM latency; its head marks the response.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_last   <= 1'b1;
            r_tag_v  <= '0;
            r_tag_id <= '0;
        end else begin
            if (w_any)
                r_last <= w_gnt1;
            r_tag_v  <= (r_tag_v << 1) | READ_LATENCY'(w_push);
            r_tag_id <= (r_tag_id << 1) | READ_LATENCY'(w_gnt1);
        end
    end

    assign m0_readdatavalid = reset_n & r_tag_v[READ_LATENCY-1]
                            & ~r_tag_id[READ_LATENCY-1];
    assign m1_readdatavalid = reset_n & r_tag_v[READ_LATENCY-1]
                            & r_tag_id[READ_LATENCY-1];
    assign m0_readdata = mem_readdata;
    assign m1_readdata = mem_readdata;

endmodule

// File: tb/tb_desc_mem_arbiter.sv
// tb_desc_mem_arbiter: directed + random stimulus against a
// transaction-level model of the two-master descriptor RAM arbiter.
module tb_desc_mem_arbiter;
  localparam int AW = 11;
  localparam int DW = 32;
  localparam int BW = 4;
  localparam int RL = 1;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic          c_rd[2];
  logic          c_wr[2];
  logic          c_lk[2];
  logic [AW-1:0] c_ad[2];
  logic [DW-1:0] c_wd[2];
  logic [BW-1:0] c_be[2];

  logic          m0_waitrequest, m1_waitrequest;
  logic [DW-1:0] m0_readdata, m1_readdata;
  logic          m0_readdatavalid, m1_readdatavalid;
  logic [AW-1:0] mem_address;
  logic [BW-1:0] mem_byteenable;
  logic          mem_chipselect, mem_write, mem_clken;
  logic [DW-1:0] mem_writedata, mem_readdata;

  desc_mem_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(RL)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .m0_address(c_ad[0]),
    .m0_byteenable(c_be[0]),
    .m0_read(c_rd[0]),
    .m0_write(c_wr[0]),
    .m0_writedata(c_wd[0]),
    .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata),
    .m0_readdatavalid(m0_readdatavalid),
    .m1_address(c_ad[1]),
    .m1_byteenable(c_be[1]),
    .m1_read(c_rd[1]),
    .m1_write(c_wr[1]),
    .m1_writedata(c_wd[1]),
    .m1_waitrequest(m1_waitrequest),
    .m1_readdata(m1_readdata),
    .m1_readdatavalid(m1_readdatavalid),
`ifdef DESC_MEM_ARB_LOCK_EN
    .m0_lock(c_lk[0]),
    .m1_lock(c_lk[1]),
`endif
    .mem_address(mem_address),
    .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect),
    .mem_write(mem_write),
    .mem_writedata(mem_writedata),
    .mem_clken(mem_clken),
    .mem_readdata(mem_readdata)
  );

  // Behavioural single-port RAM with READ_LATENCY-cycle read data.
  logic [DW-1:0] ram [2048];
  logic [DW-1:0] rq1, rq2;
  always @(posedge clk) begin
    if (mem_chipselect && mem_clken) begin
      if (mem_write) begin
        for (int b = 0; b < BW; b++)
          if (mem_byteenable[b])
            ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
      end else begin
        rq1 <= ram[mem_address];
      end
    end
    rq2 <= rq1;
  end
  assign mem_readdata = (RL == 1) ? rq1 : rq2;

  function automatic logic [DW-1:0] init_word(int i);
    logic [DW-1:0] w;
    w = DW'(i) * 32'h9E37_79B1;
    return w ^ 32'h5A5A_5A5A;
  endfunction

  typedef struct {
    int            due;
    bit            id;
    logic [DW-1:0] d;
  } rsp_t;

  logic [DW-1:0] shadow [2048];
  rsp_t          q[$];
  bit            m_last;
  bit            m_lk_v;
  bit            m_lk_id;
  int            cyc;
  bit            g[2];
  bit            acc[2];
  int            n_rdv[2];
  logic [DW-1:0] got[2];
  int            checks;
  int            errors;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)",
               tag, obs, exp, cyc);
    end
  endtask

  // One clock: check outputs mid-cycle, then advance the model at the edge.
  task automatic step();
    bit   rq[2];
    bit   cand[2];
    bit   e_rdv[2];
    bit   front;
    int   gm;
    int   o;
    rsp_t r;
    @(negedge clk);
    g[0] = 1'b0;
    g[1] = 1'b0;
    rq[0] = c_rd[0] | c_wr[0];
    rq[1] = c_rd[1] | c_wr[1];
    if (!reset_n) begin
      chk("rst_wait0", m0_waitrequest, 1);
      chk("rst_wait1", m1_waitrequest, 1);
      chk("rst_cs", mem_chipselect, 0);
      chk("rst_wr", mem_write, 0);
      chk("rst_rdv0", m0_readdatavalid, 0);
      chk("rst_rdv1", m1_readdatavalid, 0);
      chk("rst_clken", mem_clken, 0);
    end else begin
      for (int m = 0; m < 2; m++)
        cand[m] = rq[m] && !(m_lk_v && int'(m_lk_id) != m);
      if (cand[0] && cand[1])
        g[m_last ? 0 : 1] = 1'b1;
      else begin
        g[0] = cand[0];
        g[1] = cand[1];
      end
      chk("wait0", m0_waitrequest, rq[0] && !g[0]);
      chk("wait1", m1_waitrequest, rq[1] && !g[1]);
      chk("cs", mem_chipselect, g[0] || g[1]);
      chk("clken", mem_clken, 1);
      if (g[0] || g[1]) begin
        gm = g[1] ? 1 : 0;
        chk("mem_wr", mem_write, c_wr[gm]);
        chk("mem_addr", mem_address, c_ad[gm]);
        if (c_wr[gm]) begin
          chk("mem_wd", mem_writedata, c_wd[gm]);
          chk("mem_be", mem_byteenable, c_be[gm]);
        end
      end else begin
        chk("mem_wr_idle", mem_write, 0);
      end
      front = q.size() > 0 && q[0].due == cyc;
      e_rdv[0] = front && !q[0].id;
      e_rdv[1] = front && q[0].id;
      chk("rdv0", m0_readdatavalid, e_rdv[0]);
      chk("rdv1", m1_readdatavalid, e_rdv[1]);
      if (e_rdv[0]) chk("rdata0", m0_readdata, q[0].d);
      if (e_rdv[1]) chk("rdata1", m1_readdata, q[0].d);
      if (front) void'(q.pop_front());
      if (m0_readdatavalid) begin
        n_rdv[0]++;
        got[0] = m0_readdata;
      end
      if (m1_readdatavalid) begin
        n_rdv[1]++;
        got[1] = m1_readdata;
      end
    end
    @(posedge clk);
    acc[0] = 1'b0;
    acc[1] = 1'b0;
    if (!reset_n) begin
      m_last = 1'b1;
      m_lk_v = 1'b0;
      q.delete();
    end else begin
      for (int m = 0; m < 2; m++) begin
        if (g[m]) begin
          acc[m] = 1'b1;
          m_last = (m == 1);
          if (c_wr[m]) begin
            for (int b = 0; b < BW; b++)
              if (c_be[m][b])
                shadow[c_ad[m]][8*b +: 8] = c_wd[m][8*b +: 8];
          end else if (c_rd[m]) begin
            r.due = cyc + RL;
            r.id  = (m == 1);
            r.d   = shadow[c_ad[m]];
            q.push_back(r);
          end
        end
      end
      if (m_lk_v) begin
        o = m_lk_id ? 1 : 0;
        if (g[o]) m_lk_v = c_lk[o];
        else if (!rq[o] && !c_lk[o]) m_lk_v = 1'b0;
      end else begin
        for (int m = 0; m < 2; m++)
          if (!m_lk_v && g[m] && c_lk[m]) begin
            m_lk_v  = 1'b1;
            m_lk_id = (m == 1);
          end
      end
    end
    cyc++;
    #1;
  endtask

  task automatic idle(int m);
    c_rd[m] = 1'b0;
    c_wr[m] = 1'b0;
    c_lk[m] = 1'b0;
  endtask

  task automatic issue(int m, bit rd, bit wr, logic [AW-1:0] a,
                       logic [DW-1:0] d, logic [BW-1:0] be, bit lk);
    c_rd[m] = rd;
    c_wr[m] = wr;
    c_ad[m] = a;
    c_wd[m] = d;
    c_be[m] = be;
    c_lk[m] = lk;
    for (int k = 0; k < 20; k++) begin
      step();
      if (acc[m]) break;
    end
    chk("issue_accept", acc[m], 1);
    idle(m);
  endtask

  int na[2];
  int prev;
  int r;

  initial begin
    checks = 0;
    errors = 0;
    cyc = 0;
    m_last = 1'b1;
    m_lk_v = 1'b0;
    m_lk_id = 1'b0;
    for (int i = 0; i < 2048; i++) begin
      ram[i] = init_word(i);
      shadow[i] = init_word(i);
    end
    for (int m = 0; m < 2; m++) begin
      idle(m);
      c_ad[m] = '0;
      c_wd[m] = '0;
      c_be[m] = '0;
      n_rdv[m] = 0;
      got[m] = '0;
    end

    // reset held three cycles with a pending request
    c_rd[0] = 1'b1;
    repeat (3) step();
    idle(0);
    reset_n = 1'b1;
    repeat (4) step();
    chk("clken_after_rst", mem_clken, 1);
    chk("no_rdv_after_rst", n_rdv[0] + n_rdv[1], 0);

    // single master write then read
    issue(0, 0, 1, 11'h010, 32'hDEAD_BEEF, 4'hF, 0);
    issue(0, 1, 0, 11'h010, '0, 4'hF, 0);
    repeat (RL + 1) step();
    chk("sm_rdata", got[0], 32'hDEAD_BEEF);
    chk("sm_rdv1", n_rdv[1], 0);

    // byte lanes on master 1
    issue(1, 0, 1, 11'h020, 32'h1122_3344, 4'hF, 0);
    issue(1, 0, 1, 11'h020, 32'hAABB_CCDD, 4'h2, 0);
    issue(1, 1, 0, 11'h020, '0, 4'hF, 0);
    repeat (RL + 1) step();
    chk("byte_lanes", got[1], 32'h1122_CC44);

    // contention: both masters read continuously for 8 cycles
    n_rdv[0] = 0;
    n_rdv[1] = 0;
    na[0] = 0;
    na[1] = 0;
    prev = -1;
    c_rd[0] = 1'b1; c_ad[0] = 11'h000; c_be[0] = 4'hF;
    c_rd[1] = 1'b1; c_ad[1] = 11'h7FF; c_be[1] = 4'hF;
    for (int i = 0; i < 8; i++) begin
      step();
      na[0] += int'(acc[0]);
      na[1] += int'(acc[1]);
      if (prev >= 0) chk("alternate", acc[1], prev == 0);
      prev = acc[1] ? 1 : 0;
    end
    idle(0);
    idle(1);
    repeat (RL + 1) step();
    chk("ct_grants0", na[0], 4);
    chk("ct_grants1", na[1], 4);
    chk("ct_rdv0", n_rdv[0], 4);
    chk("ct_rdv1", n_rdv[1], 4);
    chk("ct_data0", got[0], init_word(0));
    chk("ct_data1", got[1], init_word(11'h7FF));

    // reset right after a read accept drops the pending response
    issue(0, 1, 0, 11'h010, '0, 4'hF, 0);
    reset_n = 1'b0;
    repeat (2) step();
    reset_n = 1'b1;
    n_rdv[0] = 0;
    n_rdv[1] = 0;
    repeat (4) step();
    chk("rst_mid_rdv", n_rdv[0] + n_rdv[1], 0);
    issue(1, 1, 0, 11'h020, '0, 4'hF, 0);
    repeat (RL) step();
    chk("post_rst_rdv", n_rdv[1], 1);

`ifdef DESC_MEM_ARB_LOCK_EN
    // locked read-modify-write by m0 while m1 keeps requesting
    c_rd[1] = 1'b1; c_ad[1] = 11'h040; c_be[1] = 4'hF;
    issue(0, 1, 0, 11'h030, '0, 4'hF, 1);
    issue(0, 0, 1, 11'h030, 32'h0BAD_F00D, 4'hF, 0);
    step();
    chk("lock_m1_next", acc[1], 1);
    idle(1);
    step();
`endif

    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      for (int m = 0; m < 2; m++) begin
        if (acc[m] || !(c_rd[m] || c_wr[m])) begin
          r = $urandom_range(0, 15);
          if (r < 4) begin
            idle(m);
          end else begin
            c_wr[m] = (r < 9) || (r == 15);
            c_rd[m] = (r >= 9);
            c_ad[m] = AW'($urandom_range(0, 15));
            c_wd[m] = $urandom;
            c_be[m] = BW'($urandom_range(0, 15));
          end
`ifdef DESC_MEM_ARB_LOCK_EN
          c_lk[m] = ($urandom_range(0, 7) == 0);
`endif
        end
      end
      step();
    end

    idle(0);
    idle(1);
    repeat (RL + 4) step();
    chk("drain", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
